// File: rtl/signmag_conv_pipe.sv
// Two-stage pipelined converter between two's-complement and sign-magnitude words.
// Flags the most-negative TC input and SM negative zero, and counts those results.
module signmag_conv_pipe #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_negz,
  output logic [CNT_W-1:0] exc_count,
  input  logic             clr_count
);

  localparam int M = WIDTH - 1;

  // Handshake: a word moves across a port on a rising edge where valid && ready.
  // A producer holds valid and its payload until accepted. in_ready is combinational
  // from out_ready, so a full pipeline can still accept a word in the cycle it drains.

  logic         s1_valid;
  logic         s1_mode;
  logic         s1_sign;
  logic [M-1:0] s1_low;
  logic [M-1:0] s1_inv;

  logic s2_load;
  logic s1_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Stage 1: capture the word, its mode, its sign and the one's complement of its low bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_low   <= '0;
      s1_inv   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_sign <= in_data[M];
        s1_low  <= in_data[M-1:0];
        s1_inv  <= ~in_data[M-1:0];
      end
    end
  end

  logic             mag_zero;
  logic [M-1:0]     neg_mag;
  logic [WIDTH-1:0] tc_neg;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_ovf;
  logic             nxt_negz;

  assign mag_zero = (s1_low == '0);
  assign neg_mag  = s1_inv + M'(1);
  assign tc_neg   = {1'b1, s1_inv} + WIDTH'(1);

  // Stage 2 datapath: the +1 and the two special cases that have no exact image.
  always_comb begin
    nxt_data = {s1_sign, s1_low};
    nxt_ovf  = 1'b0;
    nxt_negz = 1'b0;
    if (s1_sign) begin
      if (!s1_mode) begin
        if (mag_zero) begin
          nxt_data = '1;
          nxt_ovf  = 1'b1;
        end else begin
          nxt_data = {1'b1, neg_mag};
        end
      end else begin
        if (mag_zero) begin
          nxt_data = '0;
          nxt_negz = 1'b1;
        end else begin
          nxt_data = tc_neg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_negz  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= nxt_data;
        out_ovf  <= nxt_ovf;
        out_negz <= nxt_negz;
      end
    end
  end

  logic exc_fire;

  assign exc_fire = out_valid && out_ready && (out_ovf || out_negz);

  // Saturating exception counter; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    if (reset || clr_count) begin
      exc_count <= '0;
    end else if (exc_fire && (exc_count != '1)) begin
      exc_count <= exc_count + CNT_W'(1);
    end
  end

endmodule
